// File: rtl/nco_wave_gen.sv
`default_nettype none
// ============================================================================
// Module      : nco_wave_gen
// Description : Numerically controlled oscillator. Converts a Q32.32 frequency
//               word (Hz) into a phase increment with a bit-serial shift-add
//               multiply by floor(2^64 / f_clk), then runs a phase accumulator
//               that drives a registered square/PWM, sawtooth, triangle or
//               inverted-sawtooth sample stream.
// Ports       : clk            - system clock
//               reset          - asynchronous active-low reset
//               nco_enable     - run (1) / stop and clear accumulator (0)
//               nco_wave       - 00 square, 01 saw, 10 triangle, 11 inv saw
//               nco_frequency  - output frequency, Q32.32 Hz
//               nco_duty_cycle - square high fraction, duty/65536
//               wave_out       - unsigned sample, 1 cycle after phase
//               sync_pulse     - one-cycle pulse after an accumulator wrap
//               busy           - increment computation in progress
//               phase_inc      - increment currently applied to the phase
// Revision    : 1.0 - initial release
// ============================================================================
module nco_wave_gen #(
    parameter int          PHASE_W = 32,
    parameter int          OUT_W   = 12,
    parameter logic [63:0] RECIP   = 64'd184467440737,
    parameter int          RECIP_W = 38
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               nco_enable,
    input  logic [1:0]         nco_wave,
    input  logic [63:0]        nco_frequency,
    input  logic [15:0]        nco_duty_cycle,
    output logic [OUT_W-1:0]   wave_out,
    output logic               sync_pulse,
    output logic               busy,
    output logic [PHASE_W-1:0] phase_inc
);

    localparam int PROD_W = 64 + RECIP_W;
    localparam int CNT_W  = $clog2(RECIP_W + 2);

    localparam logic [RECIP_W-1:0] RECIP_BITS = RECIP[RECIP_W-1:0];
    // mult_cnt == CNT_DONE: all multiplier bits consumed, one settle edge.
    // mult_cnt == CNT_DONE+1: commit edge. This places the phase_inc update
    // RECIP_W+2 edges after the edge that captured the new frequency.
    localparam logic [CNT_W-1:0]   CNT_DONE   = CNT_W'(RECIP_W);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t               state_q,       state_d;
    logic [63:0]          freq_shadow_q, freq_shadow_d;
    logic [CNT_W-1:0]     mult_cnt_q,    mult_cnt_d;
    logic [PROD_W-1:0]    product_q,     product_d;
    logic [PHASE_W-1:0]   phase_inc_q,   phase_inc_d;
    logic                 busy_q,        busy_d;
    logic [PHASE_W-1:0]   phase_q,       phase_d;
    logic [1:0]           wave_lat_q,    wave_lat_d;
    logic [15:0]          duty_lat_q,    duty_lat_d;
    logic [OUT_W-1:0]     wave_out_q,    wave_out_d;
    logic                 sync_pulse_q,  sync_pulse_d;

    logic [PROD_W-1:0]    addend;
    logic [PHASE_W:0]     acc_sum;
    logic                 wrap;
    logic [OUT_W-1:0]     tri_s;
    logic [OUT_W-1:0]     shape;

    // ------------------------------------------------------------------
    // Frequency-to-increment conversion
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        freq_shadow_d = freq_shadow_q;
        mult_cnt_d    = mult_cnt_q;
        product_d     = product_q;
        phase_inc_d   = phase_inc_q;
        busy_d        = busy_q;
        addend        = {{RECIP_W{1'b0}}, freq_shadow_q} << mult_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (nco_frequency != freq_shadow_q) begin
                    freq_shadow_d = nco_frequency;
                    product_d     = '0;
                    mult_cnt_d    = '0;
                    busy_d        = 1'b1;
                    state_d       = ST_MUL;
                end
            end
            ST_MUL: begin
                if (nco_frequency != freq_shadow_q) begin
                    // New word arrived mid-multiply: discard partial product.
                    freq_shadow_d = nco_frequency;
                    product_d     = '0;
                    mult_cnt_d    = '0;
                end else if (mult_cnt_q < CNT_DONE) begin
                    if (RECIP_BITS[mult_cnt_q]) begin
                        product_d = product_q + addend;
                    end
                    mult_cnt_d = mult_cnt_q + 1'b1;
                end else if (mult_cnt_q == CNT_DONE) begin
                    mult_cnt_d = mult_cnt_q + 1'b1;
                end else begin
                    phase_inc_d = product_q[95 -: PHASE_W];
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase accumulator and waveform shaping
    // ------------------------------------------------------------------
    assign acc_sum = {1'b0, phase_q} + {1'b0, phase_inc_q};
    assign wrap    = acc_sum[PHASE_W];
    // Triangle folds the lower half-period bits around the phase MSB.
    assign tri_s   = phase_q[PHASE_W-2 -: OUT_W];

    always_comb begin
        shape = '0;
        case (wave_lat_q)
            2'b00:   shape = (phase_q[PHASE_W-1 -: 16] < duty_lat_q) ? {OUT_W{1'b1}} : '0;
            2'b01:   shape = phase_q[PHASE_W-1 -: OUT_W];
            2'b10:   shape = phase_q[PHASE_W-1] ? ~tri_s : tri_s;
            default: shape = ~phase_q[PHASE_W-1 -: OUT_W];
        endcase
    end

    always_comb begin
        phase_d      = phase_q;
        wave_lat_d   = wave_lat_q;
        duty_lat_d   = duty_lat_q;
        wave_out_d   = wave_out_q;
        sync_pulse_d = sync_pulse_q;

        if (nco_enable) begin
            phase_d      = acc_sum[PHASE_W-1:0];
            sync_pulse_d = wrap;
            wave_out_d   = shape;
            // Shape and duty switch only at a period boundary.
            if (wrap) begin
                wave_lat_d = nco_wave;
                duty_lat_d = nco_duty_cycle;
            end
        end else begin
            phase_d      = '0;
            sync_pulse_d = 1'b0;
            wave_out_d   = '0;
            wave_lat_d   = nco_wave;
            duty_lat_d   = nco_duty_cycle;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            freq_shadow_q <= '0;
            mult_cnt_q    <= '0;
            product_q     <= '0;
            phase_inc_q   <= '0;
            busy_q        <= 1'b0;
            phase_q       <= '0;
            wave_lat_q    <= '0;
            duty_lat_q    <= '0;
            wave_out_q    <= '0;
            sync_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            freq_shadow_q <= freq_shadow_d;
            mult_cnt_q    <= mult_cnt_d;
            product_q     <= product_d;
            phase_inc_q   <= phase_inc_d;
            busy_q        <= busy_d;
            phase_q       <= phase_d;
            wave_lat_q    <= wave_lat_d;
            duty_lat_q    <= duty_lat_d;
            wave_out_q    <= wave_out_d;
            sync_pulse_q  <= sync_pulse_d;
        end
    end

    assign wave_out   = wave_out_q;
    assign sync_pulse = sync_pulse_q;
    assign busy       = busy_q;
    assign phase_inc  = phase_inc_q;

endmodule
`default_nettype wire

// File: tb/tb_nco_wave_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_nco_wave_gen
// Description : Self-checking bench for nco_wave_gen. A cycle-level reference
//               model (countdown latency, arithmetic increment and waveform
//               formulas) is compared every cycle, plus table vectors and
//               directed corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_wave_gen;

    localparam int          PW      = 32;
    localparam int          OW      = 12;
    localparam logic [63:0] RECIP_C = 64'd184467440737;
    localparam int          LAT     = 40;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          en    = 1'b0;
    logic [1:0]    wave  = 2'b00;
    logic [63:0]   freq  = 64'd0;
    logic [15:0]   duty  = 16'd0;
    logic [OW-1:0] wave_out;
    logic          sync_pulse;
    logic          busy;
    logic [PW-1:0] phase_inc;

    always #5 clk = ~clk;

    nco_wave_gen dut (
        .clk            (clk),
        .reset          (rst_n),
        .nco_enable     (en),
        .nco_wave       (wave),
        .nco_frequency  (freq),
        .nco_duty_cycle (duty),
        .wave_out       (wave_out),
        .sync_pulse     (sync_pulse),
        .busy           (busy),
        .phase_inc      (phase_inc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model state ----------------
    logic [63:0]   m_shadow;
    int            m_cnt;
    logic          m_busy;
    logic [PW-1:0] m_inc;
    logic [PW-1:0] m_phase;
    logic [1:0]    m_wlat;
    logic [15:0]   m_dlat;
    logic [OW-1:0] m_out;
    logic          m_sync;

    function automatic logic [PW-1:0] calc_inc(input logic [63:0] f);
        logic [127:0] p;
        p = {64'd0, f} * {64'd0, RECIP_C};
        p = p / (128'd1 << 64);
        return p[PW-1:0];
    endfunction

    function automatic logic [OW-1:0] shape(input logic [PW-1:0] ph, input logic [1:0] w,
                                            input logic [15:0] d);
        int unsigned top16, saw, s;
        top16 = ph / 65536;
        saw   = ph / (1 << 20);
        s     = (ph / (1 << 19)) % 4096;
        case (w)
            2'd0:    return (top16 < d) ? 12'hFFF : 12'h000;
            2'd1:    return OW'(saw);
            2'd2:    return (ph >= 32'h8000_0000) ? OW'(4095 - s) : OW'(s);
            default: return OW'(4095 - saw);
        endcase
    endfunction

    task automatic model_reset();
        m_shadow = '0; m_cnt = 0; m_busy = 1'b0; m_inc = '0; m_phase = '0;
        m_wlat = '0; m_dlat = '0; m_out = '0; m_sync = 1'b0;
    endtask

    task automatic model_edge();
        logic [PW-1:0] old_inc;
        logic [PW:0]   sum;
        old_inc = m_inc;
        if (freq != m_shadow) begin
            m_shadow = freq;
            m_cnt    = LAT;
            m_busy   = 1'b1;
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_inc  = calc_inc(m_shadow);
                m_busy = 1'b0;
            end
        end
        if (en) begin
            m_out  = shape(m_phase, m_wlat, m_dlat);
            sum    = {1'b0, m_phase} + {1'b0, old_inc};
            m_sync = sum[PW];
            if (m_sync) begin
                m_wlat = wave;
                m_dlat = duty;
            end
            m_phase = sum[PW-1:0];
        end else begin
            m_out = '0; m_sync = 1'b0; m_phase = '0;
            m_wlat = wave; m_dlat = duty;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // One clock: update the model on the edge, compare all outputs 1 ns later.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check("model", {wave_out, sync_pulse, busy, phase_inc}, {m_out, m_sync, m_busy, m_inc});
    endtask

    // Measure one period: cycles after a sync up to and including the next sync.
    task automatic measure_period(output int high, output int per, output int maxv,
                                  output int rises);
        int prev;
        bit got;
        high = 0; per = 0; maxv = 0; rises = 0; prev = -1; got = 0;
        for (int k = 0; k < 2000 && !got; k++) begin
            step();
            if (sync_pulse) got = 1;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL sync_timeout: no sync_pulse within 2000 cycles");
            return;
        end
        got = 0;
        for (int k = 0; k < 2000 && !got; k++) begin
            step();
            per++;
            if (wave_out == 12'hFFF) high++;
            if (int'(wave_out) > maxv) maxv = int'(wave_out);
            if (prev >= 0 && int'(wave_out) > prev) rises++;
            prev = int'(wave_out);
            if (sync_pulse) got = 1;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL period_timeout: period not closed within 2000 cycles");
        end
    endtask

    typedef struct {
        logic [63:0]   f;
        logic [PW-1:0] inc;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt, last, gap, high, per, maxv, rises, nsyn, nsteps;

        tbl[0] = '{64'h0000_0001_0000_0000, 32'd42};
        tbl[1] = '{64'h000F_4240_0000_0000, 32'd42949672};
        tbl[2] = '{64'h02FA_F080_0000_0000, 32'd2147483647};
        tbl[3] = '{64'h0000_0000_0000_0000, 32'd0};
        tbl[4] = '{64'h0001_D4C0_000C_000E, 32'd5153960};
        tbl[5] = '{64'h0001_D4C0_0000_0000, 32'd5153960};

        model_reset();

        // ---- 1: reset with nonzero inputs, release with frequency 0 ----
        #1;
        rst_n = 1'b0; en = 1'b1; wave = 2'b01; freq = 64'h0001_D4C0_0000_0000; duty = 16'h8000;
        repeat (3) step();
        check("reset_outputs", {wave_out, sync_pulse, busy, phase_inc}, 64'd0);
        freq  = 64'd0;
        rst_n = 1'b1;
        repeat (5) step();
        check("release_busy", {63'd0, busy}, 64'd0);

        // ---- 2: table of frequency words, sawtooth ----
        for (int i = 0; i < 6; i++) begin
            freq = tbl[i].f; en = 1'b1; wave = 2'b01;
            bcnt = 0;
            for (int k = 0; k < LAT + 5; k++) begin
                step();
                if (busy) bcnt++;
            end
            check("busy_len", 64'(bcnt), 64'(LAT));
            check("table_inc", 64'(phase_inc), 64'(tbl[i].inc));
        end

        last = -1; maxv = 0;
        for (int k = 0; k < 2600; k++) begin
            step();
            if (int'(wave_out) > maxv) maxv = int'(wave_out);
            if (sync_pulse) begin
                if (last >= 0) begin
                    gap = k - last;
                    check_range("sync_gap", gap, 833, 834);
                end
                last = k;
            end
        end
        check_range("saw_max", maxv, 12'hFF0, 12'hFFF);

        // ---- 3: square / duty ----
        wave = 2'b00; duty = 16'h8000;
        measure_period(high, per, maxv, rises);   // shape latches at this wrap
        measure_period(high, per, maxv, rises);
        check_range("sq_period", per, 833, 834);
        check_range("sq_high_8000", high, 416, 418);
        repeat (200) step();
        duty = 16'h8181;                          // mid-period: applies at next wrap
        measure_period(high, per, maxv, rises);
        check_range("sq_high_8181", high, 420, 423);

        // ---- 4: triangle then inverted sawtooth ----
        wave = 2'b10;
        measure_period(high, per, maxv, rises);
        check_range("tri_peak", maxv, 12'hFE0, 12'hFFF);
        wave = 2'b11;
        measure_period(high, per, maxv, rises);
        check_range("inv_saw_rises", rises, 0, 0);

        // ---- 5: restart mid-computation ----
        wave = 2'b01; freq = 64'h000F_4240_0000_0000;
        repeat (LAT + 5) step();
        check("restart_base", 64'(phase_inc), 64'd42949672);
        freq = 64'h0000_0001_0000_0000;
        repeat (10) step();
        freq = 64'h0001_D4C0_000C_000E;
        bcnt = 0;
        for (int k = 1; k <= LAT + 1; k++) begin
            step();
            if (k <= LAT && busy) bcnt++;
            if (k == LAT) check("restart_hold", 64'(phase_inc), 64'd42949672);
        end
        check("restart_busy", 64'(bcnt), 64'(LAT));
        check("restart_inc", {31'd0, busy, phase_inc}, {32'd0, 32'd5153960});

        // ---- 6: enable drop, reset during multiply ----
        repeat (100) step();
        en = 1'b0;
        step();
        check("dis_wave", 64'(wave_out), 64'd0);
        nsyn = 0;
        repeat (20) begin
            step();
            if (sync_pulse) nsyn++;
        end
        check("dis_sync", 64'(nsyn), 64'd0);
        en = 1'b1;
        freq = 64'h000F_4240_0000_0000;
        repeat (15) step();
        check("mul_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst", {63'd0, busy}, 64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (LAT + 5) step();
        check("rst_recompute", 64'(phase_inc), 64'd42949672);

        // ---- random segments against the model ----
        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(0, 3) != 0)
                freq = {32'($urandom_range(0, 5000000)), 32'($urandom)};
            en     = ($urandom_range(0, 7) != 0);
            wave   = 2'($urandom);
            duty   = 16'($urandom);
            nsteps = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : $urandom_range(40, 300);
            repeat (nsteps) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
